// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory arbiter: requester ids, the
// response tag carried down the latency pipe, and the latency ceiling.
package mem_arb_pkg;

   localparam int RD_LAT_MAX = 4;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_D  = 1'b1
   } req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
      logic    is_write;
   } arb_tag_t;

   // Drops a fetch tag when a redirect is in progress; data tags pass untouched.
   function automatic arb_tag_t kill_if(input arb_tag_t t, input logic flush);
      arb_tag_t r;
      r = t;
      if (flush && (t.id == REQ_IF))
         r.valid = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Response tag pipe: RD_LAT stages tracking which requester owns each
// in-flight access, with fetch-tag invalidation on a PC redirect.
module mem_arb_tag_pipe
   import mem_arb_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic     clk,
   input  logic     reset,
   input  arb_tag_t in_tag,
   input  logic     flush_if,
   output arb_tag_t out_tag
);

   arb_tag_t stage_q [RD_LAT];

   genvar gi;
   generate
      for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
         arb_tag_t tag_reg;
         // The tag entering this cycle belongs to the redirected fetch, so it is never killed.
         if (gi == 0) begin : g_head
            always_ff @(posedge clk or negedge reset) begin
               if (!reset) tag_reg <= '0;
               else        tag_reg <= in_tag;
            end
         end else begin : g_body
            always_ff @(posedge clk or negedge reset) begin
               if (!reset) tag_reg <= '0;
               else        tag_reg <= kill_if(stage_q[gi-1], flush_if);
            end
         end
         assign stage_q[gi] = tag_reg;
      end
   endgenerate

   assign out_tag = kill_if(stage_q[RD_LAT-1], flush_if);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store, routing read data back
// after RD_LAT cycles. MEM_ARB_RR_EN selects round-robin; otherwise data wins.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req_valid,
   input  logic [ADDR_W-1:0]   if_req_addr,
   output logic                if_req_ready,
   input  logic                if_flush,
   output logic                if_rsp_valid,
   output logic [DATA_W-1:0]   if_rsp_data,
   input  logic                d_req_valid,
   input  logic                d_req_we,
   input  logic [ADDR_W-1:0]   d_req_addr,
   input  logic [DATA_W-1:0]   d_req_wdata,
   input  logic [DATA_W/8-1:0] d_req_wstrb,
   output logic                d_req_ready,
   output logic                d_rsp_valid,
   output logic [DATA_W-1:0]   d_rsp_data,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic [15:0]         arb_conflicts
);

   logic     grant_if;
   logic     grant_d;
   logic     write_grant;
   logic     rsp_read;
   logic [15:0] conflicts_reg;
   arb_tag_t in_tag;
   arb_tag_t out_tag;

`ifdef MEM_ARB_RR_EN
   req_id_t last_grant_reg;

   // On contention the side that did not win last time goes first.
   always_comb begin
      grant_d = reset && d_req_valid && (!if_req_valid || (last_grant_reg == REQ_IF));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        last_grant_reg <= REQ_IF;
      else if (grant_d)  last_grant_reg <= REQ_D;
      else if (grant_if) last_grant_reg <= REQ_IF;
   end
`else
   always_comb begin
      grant_d = reset && d_req_valid;
   end
`endif

   assign grant_if     = reset && if_req_valid && !grant_d;
   assign if_req_ready = grant_if;
   assign d_req_ready  = grant_d;
   assign write_grant  = grant_d && d_req_we;

   assign mem_en    = grant_if || grant_d;
   assign mem_we    = write_grant;
   assign mem_addr  = grant_d ? d_req_addr : (grant_if ? if_req_addr : '0);
   assign mem_wdata = write_grant ? d_req_wdata : '0;
   assign mem_wstrb = write_grant ? d_req_wstrb : '0;

   always_comb begin
      in_tag          = '0;
      in_tag.valid    = mem_en;
      in_tag.id       = grant_d ? REQ_D : REQ_IF;
      in_tag.is_write = write_grant;
   end

   mem_arb_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_tag_pipe (
      .clk      (clk),
      .reset    (reset),
      .in_tag   (in_tag),
      .flush_if (if_flush),
      .out_tag  (out_tag)
   );

   assign rsp_read     = !out_tag.is_write;
   assign if_rsp_valid = out_tag.valid && (out_tag.id == REQ_IF);
   assign d_rsp_valid  = out_tag.valid && (out_tag.id == REQ_D);
   assign if_rsp_data  = (if_rsp_valid && rsp_read) ? mem_rdata : '0;
   assign d_rsp_data   = (d_rsp_valid && rsp_read) ? mem_rdata : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         conflicts_reg <= '0;
      else if (if_req_valid && d_req_valid && (conflicts_reg != 16'hFFFF))
         conflicts_reg <= conflicts_reg + 16'd1;
   end

   assign arb_conflicts = conflicts_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level
// model (due-time response list, memory as a pure function of address).
module tb_mem_arbiter;

   localparam int RD_LAT = 3;

   typedef struct {
      int          due;
      bit          is_d;
      logic [31:0] data;
   } rsp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        if_req_valid = 1'b0;
   logic [31:0] if_req_addr = '0;
   logic        if_req_ready;
   logic        if_flush = 1'b0;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_data;
   logic        d_req_valid = 1'b0;
   logic        d_req_we = 1'b0;
   logic [31:0] d_req_addr = '0;
   logic [31:0] d_req_wdata = '0;
   logic [3:0]  d_req_wstrb = '0;
   logic        d_req_ready;
   logic        d_rsp_valid;
   logic [31:0] d_rsp_data;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata = '0;
   logic [15:0] arb_conflicts;

   mem_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .if_req_valid  (if_req_valid),
      .if_req_addr   (if_req_addr),
      .if_req_ready  (if_req_ready),
      .if_flush      (if_flush),
      .if_rsp_valid  (if_rsp_valid),
      .if_rsp_data   (if_rsp_data),
      .d_req_valid   (d_req_valid),
      .d_req_we      (d_req_we),
      .d_req_addr    (d_req_addr),
      .d_req_wdata   (d_req_wdata),
      .d_req_wstrb   (d_req_wstrb),
      .d_req_ready   (d_req_ready),
      .d_rsp_valid   (d_rsp_valid),
      .d_rsp_data    (d_rsp_data),
      .mem_en        (mem_en),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_wstrb     (mem_wstrb),
      .mem_rdata     (mem_rdata),
      .arb_conflicts (arb_conflicts)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   rsp_t        pq[$];
   logic [31:0] rd_dat [8];
   bit          rd_vld [8];
   bit          m_last_d = 1'b0;
   int unsigned m_cnt = 0;
   bit          if_pend = 1'b0;
   bit          d_pend = 1'b0;
   logic [31:0] if_a, d_a, d_wd;
   logic        d_w;
   logic [3:0]  d_st;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   task automatic clear_model();
      pq.delete();
      for (int i = 0; i < 8; i++) rd_vld[i] = 1'b0;
      m_cnt    = 0;
      m_last_d = 1'b0;
      if_pend  = 1'b0;
      d_pend   = 1'b0;
   endtask

   // One cycle held in reset: every output must read zero regardless of inputs.
   task automatic reset_step();
      @(posedge clk);
      #1;
      cyc++;
      reset        = 1'b0;
      if_req_valid = 1'($urandom_range(0, 1));
      d_req_valid  = 1'($urandom_range(0, 1));
      d_req_we     = 1'($urandom_range(0, 1));
      if_flush     = 1'($urandom_range(0, 1));
      mem_rdata    = $urandom();
      clear_model();
      #3;
      check_val("rst_if_ready", {63'd0, if_req_ready}, 64'd0);
      check_val("rst_d_ready",  {63'd0, d_req_ready},  64'd0);
      check_val("rst_if_rsp",   {31'd0, if_rsp_valid, if_rsp_data}, 64'd0);
      check_val("rst_d_rsp",    {31'd0, d_rsp_valid, d_rsp_data},   64'd0);
      check_val("rst_mem",      {26'd0, mem_en, mem_we, mem_wstrb, mem_addr}, 64'd0);
      check_val("rst_wdata",    {32'd0, mem_wdata}, 64'd0);
      check_val("rst_conflicts", {48'd0, arb_conflicts}, 64'd0);
      $display("cyc=%0d reset held", cyc);
   endtask

   task automatic cycle_step(input bit both, input bit verbose);
      rsp_t        keep[$];
      rsp_t        r;
      bit          e_ifv, e_dv, g_d, g_if;
      logic [31:0] e_ifd, e_dd, e_addr;
      @(posedge clk);
      #1;
      cyc++;
      reset = 1'b1;
      if (!if_pend && (both || $urandom_range(0, 2) != 0)) begin
         if_pend = 1'b1;
         if_a    = 32'($urandom_range(0, 1023)) << 2;
      end
      if (!d_pend && (both || $urandom_range(0, 2) != 0)) begin
         d_pend = 1'b1;
         d_a    = 32'($urandom_range(0, 1023)) << 2;
         d_w    = 1'($urandom_range(0, 1));
         d_wd   = $urandom();
         d_st   = 4'($urandom_range(0, 15));
      end
      if_req_valid = if_pend;
      if_req_addr  = if_a;
      d_req_valid  = d_pend;
      d_req_addr   = d_a;
      d_req_we     = d_w;
      d_req_wdata  = d_wd;
      d_req_wstrb  = d_st;
      if_flush     = ($urandom_range(0, 7) == 0);
      mem_rdata    = rd_vld[cyc % 8] ? rd_dat[cyc % 8] : $urandom();
      rd_vld[cyc % 8] = 1'b0;
      #3;

      if (if_flush) begin
         keep.delete();
         foreach (pq[i]) if (pq[i].is_d) keep.push_back(pq[i]);
         pq = keep;
      end
      e_ifv = 0; e_dv = 0; e_ifd = '0; e_dd = '0;
      keep.delete();
      foreach (pq[i]) begin
         if (pq[i].due == cyc) begin
            if (pq[i].is_d) begin e_dv = 1; e_dd = pq[i].data; end
            else            begin e_ifv = 1; e_ifd = pq[i].data; end
         end else begin
            keep.push_back(pq[i]);
         end
      end
      pq = keep;

`ifdef MEM_ARB_RR_EN
      g_d = d_pend && (!if_pend || !m_last_d);
`else
      g_d = d_pend;
`endif
      g_if   = if_pend && !g_d;
      e_addr = g_d ? d_a : (g_if ? if_a : 32'd0);

      check_val("if_ready",  {63'd0, if_req_ready}, {63'd0, g_if});
      check_val("d_ready",   {63'd0, d_req_ready},  {63'd0, g_d});
      check_val("mem_en",    {63'd0, mem_en},       {63'd0, (g_d || g_if)});
      check_val("mem_we",    {63'd0, mem_we},       {63'd0, (g_d && d_w)});
      check_val("mem_addr",  {32'd0, mem_addr},     {32'd0, e_addr});
      check_val("mem_wdata", {32'd0, mem_wdata},    {32'd0, (g_d && d_w) ? d_wd : 32'd0});
      check_val("mem_wstrb", {60'd0, mem_wstrb},    {60'd0, (g_d && d_w) ? d_st : 4'd0});
      check_val("if_rsp_valid", {63'd0, if_rsp_valid}, {63'd0, e_ifv});
      check_val("if_rsp_data",  {32'd0, if_rsp_data},  {32'd0, e_ifd});
      check_val("d_rsp_valid",  {63'd0, d_rsp_valid},  {63'd0, e_dv});
      check_val("d_rsp_data",   {32'd0, d_rsp_data},   {32'd0, e_dd});
      check_val("conflicts",    {48'd0, arb_conflicts}, {48'd0, 16'(m_cnt)});

      // Environment memory: return data RD_LAT cycles after a read issue.
      if (mem_en && !mem_we) begin
         rd_dat[(cyc + RD_LAT) % 8] = memf(mem_addr);
         rd_vld[(cyc + RD_LAT) % 8] = 1'b1;
      end
      if (g_d) begin
         r.due = cyc + RD_LAT; r.is_d = 1'b1; r.data = d_w ? 32'd0 : memf(d_a);
         pq.push_back(r);
         if (verbose) $display("cyc=%0d grant D %s addr=%h", cyc, d_w ? "wr" : "rd", d_a);
         d_pend   = 1'b0;
         m_last_d = 1'b1;
      end
      if (g_if) begin
         r.due = cyc + RD_LAT; r.is_d = 1'b0; r.data = memf(if_a);
         pq.push_back(r);
         if (verbose) $display("cyc=%0d grant IF addr=%h flush=%0d", cyc, if_a, if_flush);
         if_pend  = 1'b0;
         m_last_d = 1'b0;
      end
      if (if_pend && d_pend && !(g_d || g_if)) begin end
      if (if_req_valid && d_req_valid && m_cnt < 32'hFFFF) m_cnt++;
   endtask

   initial begin
      clear_model();
      reset_step();
      reset_step();
      for (int i = 0; i < 2000; i++) cycle_step(1'b0, 1'b1);
      reset_step();
      reset_step();
      for (int i = 0; i < 1500; i++) cycle_step(1'b0, 1'b1);
      $display("cyc=%0d saturation run start", cyc);
      for (int i = 0; i < 66000; i++) cycle_step(1'b1, 1'b0);
      check_val("sat_final", {48'd0, arb_conflicts}, 64'h0000_0000_0000_FFFF);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
